// File: rtl/mem_wb_stage.sv
// MEM/WB stage: formats load data and registers writeback outputs (define LOAD_ALIGN_EN for sub-word load alignment).
// Latency 1 cycle; stall_o holds upstream while a load waits for dmem_rvalid.
module mem_wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic              mem_regwrite,
  input  logic [REG_W-1:0]  mem_rd,
  input  logic [1:0]        mem_wbsel,
  input  logic [2:0]        mem_funct3,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_pc4,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall_o,
  output logic              wb_regwrite,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              wb_valid,
  output logic [31:0]       retire_cnt
);

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] WAIT_LOAD = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [REG_W-1:0]  ld_rd_q, ld_rd_d;
  logic              ld_regwrite_q, ld_regwrite_d;
  logic [2:0]        ld_funct3_q, ld_funct3_d;
  logic [1:0]        ld_addr_q, ld_addr_d;

  logic              wb_regwrite_q, wb_regwrite_d;
  logic [REG_W-1:0]  wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_wdata_q, wb_wdata_d;
  logic              wb_valid_q, wb_valid_d;
  logic [31:0]       retire_cnt_q, retire_cnt_d;

  function automatic logic [DATA_W-1:0] fmt_load(input logic [DATA_W-1:0] raw,
                                                 input logic [2:0]        f3,
                                                 input logic [1:0]        addr);
`ifdef LOAD_ALIGN_EN
    logic [7:0]  b;
    logic [15:0] h;
    b = raw[{addr, 3'b000} +: 8];
    h = raw[{addr[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  fmt_load = {{(DATA_W-8){b[7]}}, b};
      3'b100:  fmt_load = {{(DATA_W-8){1'b0}}, b};
      3'b001:  fmt_load = {{(DATA_W-16){h[15]}}, h};
      3'b101:  fmt_load = {{(DATA_W-16){1'b0}}, h};
      default: fmt_load = raw;
    endcase
`else
    logic unused_sel;
    unused_sel = ^{f3, addr};
    fmt_load   = raw;
`endif
  endfunction

  assign stall_o = (state_q == WAIT_LOAD) ||
                   (mem_valid && (mem_wbsel == 2'b01) && !dmem_rvalid);

  always_comb begin
    state_d       = state_q;
    ld_rd_d       = ld_rd_q;
    ld_regwrite_d = ld_regwrite_q;
    ld_funct3_d   = ld_funct3_q;
    ld_addr_d     = ld_addr_q;
    wb_valid_d    = 1'b0;
    wb_regwrite_d = 1'b0;
    wb_rd_d       = wb_rd_q;
    wb_wdata_d    = wb_wdata_q;
    retire_cnt_d  = retire_cnt_q;

    case (state_q)
      IDLE: begin
        if (mem_valid) begin
          if ((mem_wbsel == 2'b01) && !dmem_rvalid) begin
            state_d       = WAIT_LOAD;
            ld_rd_d       = mem_rd;
            ld_regwrite_d = mem_regwrite;
            ld_funct3_d   = mem_funct3;
            ld_addr_d     = mem_alu_result[1:0];
          end else begin
            wb_valid_d    = 1'b1;
            wb_rd_d       = mem_rd;
            // x0 is never written, but the instruction still retires
            wb_regwrite_d = mem_regwrite && (mem_rd != '0);
            case (mem_wbsel)
              2'b01:   wb_wdata_d = fmt_load(dmem_rdata, mem_funct3, mem_alu_result[1:0]);
              2'b10:   wb_wdata_d = mem_pc4;
              default: wb_wdata_d = mem_alu_result;
            endcase
          end
        end
      end
      default: begin
        // mem_* is ignored here; only the latched load fields are used
        if (dmem_rvalid) begin
          state_d       = IDLE;
          wb_valid_d    = 1'b1;
          wb_rd_d       = ld_rd_q;
          wb_regwrite_d = ld_regwrite_q && (ld_rd_q != '0);
          wb_wdata_d    = fmt_load(dmem_rdata, ld_funct3_q, ld_addr_q);
        end
      end
    endcase

    if (wb_valid_d) retire_cnt_d = retire_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      ld_rd_q       <= '0;
      ld_regwrite_q <= 1'b0;
      ld_funct3_q   <= '0;
      ld_addr_q     <= '0;
      wb_regwrite_q <= 1'b0;
      wb_rd_q       <= '0;
      wb_wdata_q    <= '0;
      wb_valid_q    <= 1'b0;
      retire_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      ld_rd_q       <= ld_rd_d;
      ld_regwrite_q <= ld_regwrite_d;
      ld_funct3_q   <= ld_funct3_d;
      ld_addr_q     <= ld_addr_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_rd_q       <= wb_rd_d;
      wb_wdata_q    <= wb_wdata_d;
      wb_valid_q    <= wb_valid_d;
      retire_cnt_q  <= retire_cnt_d;
    end
  end

  assign wb_regwrite = wb_regwrite_q;
  assign wb_rd       = wb_rd_q;
  assign wb_wdata    = wb_wdata_q;
  assign wb_valid    = wb_valid_q;
  assign retire_cnt  = retire_cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed steps followed by random traffic against a behavioural model.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic        mem_regwrite;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wbsel;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_pc4;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        stall_o;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wdata;
  logic        wb_valid;
  logic [31:0] retire_cnt;

  int checks   = 0;
  int failures = 0;

  // model: one optional pending load plus the expected writeback outputs
  bit          m_pend = 1'b0;
  logic [4:0]  m_prd;
  bit          m_prw;
  logic [2:0]  m_pf3;
  logic [1:0]  m_paddr;
  bit          e_valid = 1'b0;
  bit          e_rw    = 1'b0;
  logic [4:0]  e_rd    = '0;
  logic [31:0] e_wdata = '0;
  logic [31:0] e_cnt   = '0;

  mem_wb_stage #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
    .mem_wbsel(mem_wbsel), .mem_funct3(mem_funct3), .mem_alu_result(mem_alu_result),
    .mem_pc4(mem_pc4), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .stall_o(stall_o), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .wb_wdata(wb_wdata), .wb_valid(wb_valid), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_fmt(input logic [31:0] raw, input logic [2:0] f3,
                                        input logic [1:0] a);
    logic [31:0] byte_v, half_v;
    byte_v = (raw >> (8 * a)) & 32'hFF;
    half_v = (raw >> (16 * a[1])) & 32'hFFFF;
`ifdef LOAD_ALIGN_EN
    case (f3)
      3'd0:    return (byte_v >= 32'h80)   ? (byte_v | 32'hFFFFFF00) : byte_v;
      3'd4:    return byte_v;
      3'd1:    return (half_v >= 32'h8000) ? (half_v | 32'hFFFF0000) : half_v;
      3'd5:    return half_v;
      default: return raw;
    endcase
`else
    return raw + 0 * (byte_v + half_v + 32'(f3));
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit v, input bit rw, input logic [4:0] rd, input logic [1:0] sel,
                        input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc4,
                        input bit rv, input logic [31:0] rdata);
    mem_valid = v; mem_regwrite = rw; mem_rd = rd; mem_wbsel = sel; mem_funct3 = f3;
    mem_alu_result = alu; mem_pc4 = pc4; dmem_rvalid = rv; dmem_rdata = rdata;
  endtask

  // One clock: check stall_o on the current inputs, advance the model, check registered outputs.
  task automatic step(input string tag);
    bit retire;
    #1;
    chk({tag, ".stall"}, 32'(stall_o),
        32'(m_pend || (mem_valid && mem_wbsel == 2'b01 && !dmem_rvalid)));
    retire = 1'b0;
    if (reset) begin
      m_pend = 1'b0; e_valid = 1'b0; e_rw = 1'b0; e_rd = '0; e_wdata = '0; e_cnt = '0;
    end else if (m_pend) begin
      if (dmem_rvalid) begin
        retire = 1'b1; m_pend = 1'b0;
        e_rd = m_prd; e_rw = m_prw && (m_prd != 0); e_wdata = m_fmt(dmem_rdata, m_pf3, m_paddr);
      end
    end else if (mem_valid) begin
      if (mem_wbsel == 2'b01 && !dmem_rvalid) begin
        m_pend = 1'b1; m_prd = mem_rd; m_prw = mem_regwrite;
        m_pf3 = mem_funct3; m_paddr = mem_alu_result[1:0];
      end else begin
        retire = 1'b1;
        e_rd = mem_rd; e_rw = mem_regwrite && (mem_rd != 0);
        e_wdata = (mem_wbsel == 2'b10) ? mem_pc4 :
                  (mem_wbsel == 2'b01) ? m_fmt(dmem_rdata, mem_funct3, mem_alu_result[1:0]) :
                  mem_alu_result;
      end
    end
    if (!reset) begin
      e_valid = retire;
      if (!retire) e_rw = 1'b0;
      if (retire) e_cnt = e_cnt + 32'd1;
    end
    @(posedge clk);
    #1;
    chk({tag, ".wb_valid"},    32'(wb_valid),    32'(e_valid));
    chk({tag, ".wb_regwrite"}, 32'(wb_regwrite), 32'(e_rw));
    chk({tag, ".wb_rd"},       32'(wb_rd),       32'(e_rd));
    chk({tag, ".wb_wdata"},    wb_wdata,         e_wdata);
    chk({tag, ".retire_cnt"},  retire_cnt,       e_cnt);
  endtask

  initial begin
    reset = 1'b1;
    set_in(0, 0, 5'd0, 2'b00, 3'd0, 32'd0, 32'd0, 0, 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // reset wins over a valid instruction
    set_in(1, 1, 5'd3, 2'b00, 3'd0, 32'h55, 32'd0, 0, 32'd0);
    step("reset");

    reset = 1'b0;
    set_in(1, 1, 5'd5, 2'b00, 3'd2, 32'h1234, 32'h4, 0, 32'd0);
    step("alu");
    chk("alu.const_wdata", wb_wdata, 32'h1234);
    chk("alu.const_cnt", retire_cnt, 32'd1);

    // load stalls with rvalid low; mem_* changes while waiting must be ignored
    set_in(1, 1, 5'd7, 2'b01, 3'b010, 32'h100, 32'h8, 0, 32'd0);
    step("ld_wait0");
    set_in(1, 1, 5'd9, 2'b00, 3'b000, 32'h777, 32'hC, 0, 32'd0);
    step("ld_wait1");
    step("ld_wait2");
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
    step("ld_done");
    chk("ld_done.const_wdata", wb_wdata, 32'hDEADBEEF);

    set_in(0, 1, 5'd4, 2'b00, 3'd0, 32'h999, 32'h0, 0, 32'd0);
    step("idle");

    set_in(1, 1, 5'd0, 2'b10, 3'd0, 32'h40, 32'h104, 0, 32'd0);
    step("jal_x0");
    chk("jal_x0.const_wdata", wb_wdata, 32'h104);

    set_in(1, 1, 5'd10, 2'b01, 3'b000, 32'h203, 32'h0, 1, 32'h80FFFFFF);
    step("lb");
    set_in(1, 1, 5'd11, 2'b01, 3'b101, 32'h202, 32'h0, 1, 32'h80FFFFFF);
    step("lhu");
`ifdef LOAD_ALIGN_EN
    chk("lhu.const_wdata", wb_wdata, 32'h000080FF);
`endif

    // reset while a load is pending discards it, even with rvalid high
    set_in(1, 1, 5'd12, 2'b01, 3'b010, 32'h300, 32'h0, 0, 32'd0);
    step("rst_ld_wait");
    reset = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
    step("rst_ld_reset");
    reset = 1'b0;
    set_in(0, 0, 5'd0, 2'b00, 3'd0, 32'd0, 32'd0, 1, 32'h12345678);
    step("rst_ld_after");

    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      set_in(bit'($urandom_range(0, 3) != 0), bit'($urandom), 5'($urandom), 2'($urandom),
             3'($urandom), $urandom, $urandom, bit'($urandom), $urandom);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
